// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core_l0 memory path.
// Contents:
//   - Memory access-type codes (BYTE/HALF/WORD_MEM_ACCESS).
//   - Arbiter FSM state and transaction-owner enums.
//   - is_aligned(): alignment rule for a given access type.
package mem_arbiter_pkg;

   localparam logic [1:0] BYTE_MEM_ACCESS = 2'b00;
   localparam logic [1:0] HALF_MEM_ACCESS = 2'b01;
   localparam logic [1:0] WORD_MEM_ACCESS = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_t;

   // BYTE is always aligned, HALF needs an even address, and anything
   // else is treated as WORD and needs a 4-byte aligned address.
   function automatic logic is_aligned(input logic [1:0] acc_type,
                                       input logic [1:0] addr_lo);
      case (acc_type)
         BYTE_MEM_ACCESS: return 1'b1;
         HALF_MEM_ACCESS: return (addr_lo[0] == 1'b0);
         default:         return (addr_lo == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (I fetch, D load/store), the
// arbiter and the single-ported unified memory.
// Signals:
//   i_req_* / i_rsp_* : instruction-fetch request/response handshake
//   d_req_* / d_rsp_* : load/store request/response handshake
//   mem_*             : memory command and combinational read data
// Modports:
//   slave  : the arbiter
//   master : the requesters and the memory (the surrounding system)
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_req_valid;
   logic                  i_req_ready;
   logic [DATA_WIDTH-1:0] i_req_addr;
   logic                  i_rsp_valid;
   logic                  i_rsp_ready;
   logic [DATA_WIDTH-1:0] i_rsp_data;
   logic                  i_rsp_err;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic [DATA_WIDTH-1:0] d_req_addr;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic                  d_req_write;
   logic [1:0]            d_req_type;
   logic                  d_rsp_valid;
   logic                  d_rsp_ready;
   logic [DATA_WIDTH-1:0] d_rsp_data;
   logic                  d_rsp_err;

   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_write;
   logic                  mem_read;
   logic [1:0]            mem_access_type;
   logic [DATA_WIDTH-1:0] mem_data_out;

   modport slave (
      input  i_req_valid, i_req_addr, i_rsp_ready,
      input  d_req_valid, d_req_addr, d_req_wdata, d_req_write, d_req_type,
      input  d_rsp_ready,
      input  mem_data_out,
      output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
      output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
      output mem_addr, mem_data_in, mem_write, mem_read, mem_access_type
   );

   modport master (
      output i_req_valid, i_req_addr, i_rsp_ready,
      output d_req_valid, d_req_addr, d_req_wdata, d_req_write, d_req_type,
      output d_rsp_ready,
      output mem_data_out,
      input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
      input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
      input  mem_addr, mem_data_in, mem_write, mem_read, mem_access_type
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick between the fetch (I) and data (D) ports.
// Ports:
//   i_valid, d_valid : request valids of the two ports
//   last_grant       : owner of the most recently accepted request
//   i_grant, d_grant : one-hot (or zero) winner
// A lone valid always wins; on a tie the port not granted last time wins.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic   i_valid,
   input  logic   d_valid,
   input  owner_t last_grant,
   output logic   i_grant,
   output logic   d_grant
);

   always_comb begin
      i_grant = i_valid && (!d_valid || (last_grant == OWNER_D));
      d_grant = d_valid && (!i_valid || (last_grant == OWNER_I));
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing the single-ported core_l0 memory between the
// instruction-fetch port and the load/store port. One transaction is in
// flight at a time: IDLE (accept) -> ACCESS (1 cycle) -> RESP (hold until
// consumed). Misaligned requests skip ACCESS and answer with err = 1.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mem_arbiter_if.slave (I/D handshakes and memory command)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   arb_state_t            state, state_nx;
   owner_t                last_grant, owner;

   logic [DATA_WIDTH-1:0] lat_addr, lat_wdata, rsp_data;
   logic                  lat_write, rsp_err;
   logic [1:0]            lat_type;

   logic                  i_grant, d_grant;
   logic                  accept;
   owner_t                acc_owner;
   logic [DATA_WIDTH-1:0] acc_addr, acc_wdata;
   logic                  acc_write, acc_aligned;
   logic [1:0]            acc_type;
   logic                  rsp_taken;

   logic [DATA_WIDTH-1:0] m_addr, m_data_in;
   logic                  m_read, m_write;
   logic [1:0]            m_type;

   rr_arbiter2 u_rr (
      .i_valid    (bus.i_req_valid),
      .d_valid    (bus.d_req_valid),
      .last_grant (last_grant),
      .i_grant    (i_grant),
      .d_grant    (d_grant)
   );

   assign bus.i_req_ready = (state == IDLE) && !rst && i_grant;
   assign bus.d_req_ready = (state == IDLE) && !rst && d_grant;

   // Fetches are forced to word reads regardless of the D-side fields.
   always_comb begin
      if (i_grant) begin
         acc_owner = OWNER_I;
         acc_addr  = bus.i_req_addr;
         acc_wdata = '0;
         acc_write = 1'b0;
         acc_type  = WORD_MEM_ACCESS;
      end else begin
         acc_owner = OWNER_D;
         acc_addr  = bus.d_req_addr;
         acc_wdata = bus.d_req_wdata;
         acc_write = bus.d_req_write;
         acc_type  = bus.d_req_type;
      end
      acc_aligned = is_aligned(acc_type, acc_addr[1:0]);
      accept      = (bus.i_req_ready && bus.i_req_valid) ||
                    (bus.d_req_ready && bus.d_req_valid);
      rsp_taken   = (owner == OWNER_I) ? bus.i_rsp_ready : bus.d_rsp_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = acc_aligned ? ACCESS : RESP;
         ACCESS:  state_nx = RESP;
         RESP:    if (rsp_taken) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= OWNER_D;
         owner      <= OWNER_I;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_write  <= 1'b0;
         lat_type   <= WORD_MEM_ACCESS;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else if (accept) begin
         owner      <= acc_owner;
         last_grant <= acc_owner;
         lat_addr   <= acc_addr;
         lat_wdata  <= acc_wdata;
         lat_write  <= acc_write;
         lat_type   <= acc_type;
         rsp_data   <= '0;
         rsp_err    <= !acc_aligned;
      end else if (state == ACCESS) begin
         rsp_data   <= lat_write ? '0 : bus.mem_data_out;
         rsp_err    <= 1'b0;
      end
   end

   // Read/write strobes are gated by rst so a reset landing in ACCESS
   // never commits a store.
   always_comb begin
      m_addr    = '0;
      m_data_in = '0;
      m_read    = 1'b0;
      m_write   = 1'b0;
      m_type    = WORD_MEM_ACCESS;
      if (state == ACCESS) begin
         m_addr    = lat_addr;
         m_data_in = lat_wdata;
         m_type    = lat_type;
         m_read    = !lat_write && !rst;
         m_write   = lat_write && !rst;
      end
   end

   assign bus.mem_addr        = m_addr;
   assign bus.mem_data_in     = m_data_in;
   assign bus.mem_read        = m_read;
   assign bus.mem_write       = m_write;
   assign bus.mem_access_type = m_type;

   assign bus.i_rsp_valid = (state == RESP) && (owner == OWNER_I);
   assign bus.d_rsp_valid = (state == RESP) && (owner == OWNER_D);
   assign bus.i_rsp_data  = rsp_data;
   assign bus.d_rsp_data  = rsp_data;
   assign bus.i_rsp_err   = rsp_err;
   assign bus.d_rsp_err   = rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-addressed
// little-endian memory model (combinational read, write on clock edge).
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk;
   logic rst;
   logic mem_init;
   int   n_checks;
   int   n_fail;

   mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   mem_arbiter #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model
   logic [7:0]  mem [0:4095];
   logic [11:0] ma0, ma1, ma2, ma3;

   always_comb begin
      ma0 = bus.mem_addr[11:0];
      ma1 = ma0 + 12'd1;
      ma2 = ma0 + 12'd2;
      ma3 = ma0 + 12'd3;
      case (bus.mem_access_type)
         BYTE_MEM_ACCESS: bus.mem_data_out = {24'h0, mem[ma0]};
         HALF_MEM_ACCESS: bus.mem_data_out = {16'h0, mem[ma1], mem[ma0]};
         default:         bus.mem_data_out = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      endcase
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
      end else if (bus.mem_write) begin
         mem[ma0] <= bus.mem_data_in[7:0];
         if (bus.mem_access_type != BYTE_MEM_ACCESS)
            mem[ma1] <= bus.mem_data_in[15:8];
         if (bus.mem_access_type != BYTE_MEM_ACCESS &&
             bus.mem_access_type != HALF_MEM_ACCESS) begin
            mem[ma2] <= bus.mem_data_in[23:16];
            mem[ma3] <= bus.mem_data_in[31:24];
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one D transaction (no I contention assumed) and reports what
   // was seen; callers do their own comparisons.
   task automatic run_d(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wr, input logic [1:0] typ,
                        output logic [31:0] data, output logic err,
                        output logic [1:0] seen_type, output logic seen_wr,
                        output logic timed_out);
      int n;
      timed_out = 1'b0;
      seen_type = WORD_MEM_ACCESS;
      seen_wr   = 1'b0;
      data      = '0;
      err       = 1'b0;
      bus.d_req_addr  = addr;
      bus.d_req_wdata = wdata;
      bus.d_req_write = wr;
      bus.d_req_type  = typ;
      bus.d_req_valid = 1'b1;
      #1;
      n = 0;
      while (!bus.d_req_ready && n < 10) begin tick(); #1; n++; end
      if (!bus.d_req_ready) begin
         bus.d_req_valid = 1'b0;
         timed_out = 1'b1;
         return;
      end
      tick();
      bus.d_req_valid = 1'b0;
      #1;
      if (bus.mem_read || bus.mem_write) seen_type = bus.mem_access_type;
      seen_wr = bus.mem_write;
      n = 0;
      while (!bus.d_rsp_valid && n < 10) begin tick(); #1; n++; end
      if (!bus.d_rsp_valid) begin
         timed_out = 1'b1;
         return;
      end
      data = bus.d_rsp_data;
      err  = bus.d_rsp_err;
      bus.d_rsp_ready = 1'b1;
      tick();
      bus.d_rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      mem_init = 1'b1;
      rst = 1'b1;
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h0;
      bus.d_req_type  = WORD_MEM_ACCESS;
      tick();
      n_checks++;
      if (bus.d_req_ready !== 1'b0) begin
         $display("FAIL reset_ready_gated: got %b want 0", bus.d_req_ready); n_fail++;
      end
      tick();
      rst = 1'b0;
      mem_init = 1'b0;
      bus.d_req_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin
         $display("FAIL reset_rsp_valid: got i=%b d=%b want 0 0", bus.i_rsp_valid, bus.d_rsp_valid); n_fail++;
      end
      n_checks++;
      if (bus.d_rsp_data !== 32'h0 || bus.d_rsp_err !== 1'b0) begin
         $display("FAIL reset_rsp_data: got %h/%b want 0/0", bus.d_rsp_data, bus.d_rsp_err); n_fail++;
      end
      n_checks++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 ||
          bus.mem_access_type !== WORD_MEM_ACCESS) begin
         $display("FAIL reset_mem_idle: got rd=%b wr=%b addr=%h type=%b want 0 0 0 %b",
                  bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_access_type, WORD_MEM_ACCESS);
         n_fail++;
      end
   endtask

   task automatic test_store_load;
      logic [31:0] data; logic err, wr, to; logic [1:0] ty;
      bus.d_req_addr  = 32'h100;
      bus.d_req_wdata = 32'hDEADBEEF;
      bus.d_req_write = 1'b1;
      bus.d_req_type  = WORD_MEM_ACCESS;
      bus.d_req_valid = 1'b1;
      #1;
      n_checks++;
      if (bus.d_req_ready !== 1'b1) begin
         $display("FAIL store_ready_idle: got %b want 1", bus.d_req_ready); n_fail++;
      end
      tick();
      bus.d_req_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_data_in !== 32'hDEADBEEF ||
          bus.mem_read !== 1'b0) begin
         $display("FAIL store_access: got wr=%b rd=%b addr=%h din=%h want 1 0 100 deadbeef",
                  bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_data_in);
         n_fail++;
      end
      n_checks++;
      if (bus.d_rsp_valid !== 1'b0) begin
         $display("FAIL store_latency_early: got %b want 0", bus.d_rsp_valid); n_fail++;
      end
      tick();
      n_checks++;
      if (bus.mem_write !== 1'b0) begin
         $display("FAIL store_write_one_cycle: got %b want 0", bus.mem_write); n_fail++;
      end
      n_checks++;
      if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== 32'h0 || bus.d_rsp_err !== 1'b0) begin
         $display("FAIL store_rsp: got v=%b d=%h e=%b want 1 0 0", bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err);
         n_fail++;
      end
      bus.d_rsp_ready = 1'b1;
      tick();
      bus.d_rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.d_rsp_valid !== 1'b0) begin
         $display("FAIL store_rsp_drop: got %b want 0", bus.d_rsp_valid); n_fail++;
      end
      run_d(32'h100, 32'h0, 1'b0, WORD_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || data !== 32'hDEADBEEF || err !== 1'b0) begin
         $display("FAIL load_word: got %h err=%b timeout=%b want deadbeef 0 0", data, err, to); n_fail++;
      end
   endtask

   task automatic test_round_robin;
      logic got [0:3];
      logic want [0:3];
      int ng;
      want[0] = 1'b1; want[1] = 1'b0; want[2] = 1'b1; want[3] = 1'b0; // 1 = I
      for (int k = 0; k < 4; k++) got[k] = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      bus.i_req_addr  = 32'h100;
      bus.d_req_addr  = 32'h100;
      bus.d_req_write = 1'b0;
      bus.d_req_type  = WORD_MEM_ACCESS;
      bus.i_req_valid = 1'b1;
      bus.d_req_valid = 1'b1;
      bus.i_rsp_ready = 1'b1;
      bus.d_rsp_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 30 && ng < 4; c++) begin
         #1;
         n_checks++;
         if (bus.i_req_ready === 1'b1 && bus.d_req_ready === 1'b1) begin
            $display("FAIL rr_both_ready: got 1 1 want at most one"); n_fail++;
         end
         n_checks++;
         if (bus.i_rsp_valid === 1'b1 && bus.d_rsp_valid === 1'b1) begin
            $display("FAIL rr_both_rsp: got 1 1 want at most one"); n_fail++;
         end
         if (bus.i_rsp_valid === 1'b1) begin
            n_checks++;
            if (bus.i_rsp_data !== 32'hDEADBEEF || bus.i_rsp_err !== 1'b0) begin
               $display("FAIL rr_i_data: got %h/%b want deadbeef/0", bus.i_rsp_data, bus.i_rsp_err); n_fail++;
            end
         end
         if (bus.i_req_ready === 1'b1 && ng < 4) begin got[ng] = 1'b1; ng++; end
         else if (bus.d_req_ready === 1'b1 && ng < 4) begin got[ng] = 1'b0; ng++; end
         tick();
      end
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      n_checks++;
      if (ng != 4) begin
         $display("FAIL rr_timeout: got %0d grants want 4", ng); n_fail++;
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (got[k] !== want[k]) begin
            $display("FAIL rr_order[%0d]: got %s want %s", k, got[k] ? "I" : "D", want[k] ? "I" : "D"); n_fail++;
         end
      end
      for (int k = 0; k < 6; k++) tick();
      bus.i_rsp_ready = 1'b0;
      bus.d_rsp_ready = 1'b0;
   endtask

   task automatic test_misaligned;
      logic [31:0] data; logic err, wr, to; logic [1:0] ty;
      run_d(32'h203, 32'h0000005A, 1'b1, BYTE_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || err !== 1'b0 || wr !== 1'b1) begin
         $display("FAIL mis_prefill: got err=%b wr=%b timeout=%b want 0 1 0", err, wr, to); n_fail++;
      end
      bus.d_req_addr  = 32'h203;
      bus.d_req_wdata = 32'h1234;
      bus.d_req_write = 1'b1;
      bus.d_req_type  = HALF_MEM_ACCESS;
      bus.d_req_valid = 1'b1;
      #1;
      n_checks++;
      if (bus.d_req_ready !== 1'b1) begin
         $display("FAIL mis_ready: got %b want 1", bus.d_req_ready); n_fail++;
      end
      tick();
      bus.d_req_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_err !== 1'b1 || bus.d_rsp_data !== 32'h0) begin
         $display("FAIL mis_rsp: got v=%b e=%b d=%h want 1 1 0", bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data);
         n_fail++;
      end
      n_checks++;
      if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
         $display("FAIL mis_no_mem: got wr=%b rd=%b want 0 0", bus.mem_write, bus.mem_read); n_fail++;
      end
      bus.d_rsp_ready = 1'b1;
      tick();
      bus.d_rsp_ready = 1'b0;
      run_d(32'h203, 32'h0, 1'b0, BYTE_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || data !== 32'h0000005A || err !== 1'b0 || ty !== BYTE_MEM_ACCESS) begin
         $display("FAIL mis_readback: got %h err=%b type=%b timeout=%b want 0000005a 0 %b 0",
                  data, err, ty, to, BYTE_MEM_ACCESS);
         n_fail++;
      end
   endtask

   task automatic test_sub_word;
      logic [31:0] data; logic err, wr, to; logic [1:0] ty;
      run_d(32'h300, 32'h000000AB, 1'b1, BYTE_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || ty !== BYTE_MEM_ACCESS || wr !== 1'b1) begin
         $display("FAIL sub_byte_type: got %b wr=%b timeout=%b want %b 1 0", ty, wr, to, BYTE_MEM_ACCESS); n_fail++;
      end
      run_d(32'h302, 32'h0000CDEF, 1'b1, HALF_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || ty !== HALF_MEM_ACCESS || wr !== 1'b1 || err !== 1'b0) begin
         $display("FAIL sub_half_type: got %b wr=%b err=%b timeout=%b want %b 1 0 0", ty, wr, err, to, HALF_MEM_ACCESS);
         n_fail++;
      end
      run_d(32'h300, 32'h0, 1'b0, WORD_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || data !== 32'hCDEF00AB || ty !== WORD_MEM_ACCESS || wr !== 1'b0) begin
         $display("FAIL sub_word_load: got %h type=%b wr=%b timeout=%b want cdef00ab %b 0 0",
                  data, ty, wr, to, WORD_MEM_ACCESS);
         n_fail++;
      end
   endtask

   task automatic test_back_pressure;
      bus.d_req_addr  = 32'h100;
      bus.d_req_write = 1'b0;
      bus.d_req_type  = WORD_MEM_ACCESS;
      bus.d_req_valid = 1'b1;
      bus.d_rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.d_req_ready !== 1'b1) begin
         $display("FAIL bp_d_ready: got %b want 1", bus.d_req_ready); n_fail++;
      end
      tick();
      bus.d_req_valid = 1'b0;
      bus.i_req_addr  = 32'h300;
      bus.i_req_valid = 1'b1;
      bus.i_rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.i_req_ready !== 1'b0) begin
         $display("FAIL bp_i_ready_access: got %b want 0", bus.i_req_ready); n_fail++;
      end
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_data !== 32'hDEADBEEF || bus.i_req_ready !== 1'b0 ||
             bus.i_rsp_valid !== 1'b0) begin
            $display("FAIL bp_hold[%0d]: got dv=%b d=%h ir=%b iv=%b want 1 deadbeef 0 0",
                     k, bus.d_rsp_valid, bus.d_rsp_data, bus.i_req_ready, bus.i_rsp_valid);
            n_fail++;
         end
         tick();
      end
      bus.d_rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.i_req_ready !== 1'b0) begin
         $display("FAIL bp_no_same_cycle: got %b want 0", bus.i_req_ready); n_fail++;
      end
      tick();
      bus.d_rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.d_rsp_valid !== 1'b0 || bus.i_req_ready !== 1'b1) begin
         $display("FAIL bp_i_accept: got dv=%b ir=%b want 0 1", bus.d_rsp_valid, bus.i_req_ready); n_fail++;
      end
      tick();
      bus.i_req_valid = 1'b0;
      tick();
      #1;
      n_checks++;
      if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_data !== 32'hCDEF00AB || bus.i_rsp_err !== 1'b0) begin
         $display("FAIL bp_i_rsp: got v=%b d=%h e=%b want 1 cdef00ab 0", bus.i_rsp_valid, bus.i_rsp_data, bus.i_rsp_err);
         n_fail++;
      end
      tick();
      bus.i_rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_access;
      logic [31:0] data; logic err, wr, to; logic [1:0] ty;
      run_d(32'h400, 32'h11223344, 1'b1, WORD_MEM_ACCESS, data, err, ty, wr, to);
      bus.d_req_addr  = 32'h400;
      bus.d_req_wdata = 32'h00000055;
      bus.d_req_write = 1'b1;
      bus.d_req_type  = WORD_MEM_ACCESS;
      bus.d_req_valid = 1'b1;
      #1;
      n_checks++;
      if (bus.d_req_ready !== 1'b1) begin
         $display("FAIL rmid_ready: got %b want 1", bus.d_req_ready); n_fail++;
      end
      tick();
      bus.d_req_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.mem_write !== 1'b0) begin
         $display("FAIL rmid_write_gated: got %b want 0", bus.mem_write); n_fail++;
      end
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0 || bus.d_rsp_data !== 32'h0) begin
         $display("FAIL rmid_rsp_cleared: got dv=%b iv=%b d=%h want 0 0 0",
                  bus.d_rsp_valid, bus.i_rsp_valid, bus.d_rsp_data);
         n_fail++;
      end
      bus.d_req_write = 1'b0;
      bus.d_req_valid = 1'b1;
      #1;
      n_checks++;
      if (bus.d_req_ready !== 1'b1) begin
         $display("FAIL rmid_idle: got ready %b want 1", bus.d_req_ready); n_fail++;
      end
      run_d(32'h400, 32'h0, 1'b0, WORD_MEM_ACCESS, data, err, ty, wr, to);
      n_checks++;
      if (to || data !== 32'h11223344 || err !== 1'b0) begin
         $display("FAIL rmid_old_value: got %h err=%b timeout=%b want 11223344 0 0", data, err, to); n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      mem_init = 1'b1;
      bus.i_req_valid = 1'b0;
      bus.i_req_addr  = '0;
      bus.i_rsp_ready = 1'b0;
      bus.d_req_valid = 1'b0;
      bus.d_req_addr  = '0;
      bus.d_req_wdata = '0;
      bus.d_req_write = 1'b0;
      bus.d_req_type  = WORD_MEM_ACCESS;
      bus.d_rsp_ready = 1'b0;
      test_reset();
      test_store_load();
      test_round_robin();
      test_misaligned();
      test_sub_word();
      test_back_pressure();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported unified memory (WORDS x DATA_WIDTH, byte/half/word access) in core_l0.
- Shares the memory between the instruction-fetch port (I) and the load/store port (D) using valid/ready request and response handshakes.
- One transaction is in flight at a time. Grants are round-robin on contention.
- Misaligned requests are rejected with an error response and never reach the memory.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  DATA_WIDTH  fetch byte address; always a WORD read.
- i_rsp_valid  out  1  fetch response valid.
- i_rsp_ready  in  1  fetch response consumed.
- i_rsp_data  out  DATA_WIDTH  fetched word.
- i_rsp_err  out  1  misaligned fetch.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted.
- d_req_addr  in  DATA_WIDTH  data byte address.
- d_req_wdata  in  DATA_WIDTH  store data; low bits used for half/byte.
- d_req_write  in  1  1 = store, 0 = load.
- d_req_type  in  2  WORD/HALF/BYTE_MEM_ACCESS.
- d_rsp_valid  out  1  data response valid.
- d_rsp_ready  in  1  data response consumed.
- d_rsp_data  out  DATA_WIDTH  load data (zero-extended by memory); 0 for stores.
- d_rsp_err  out  1  misaligned data access.
- mem_addr  out  DATA_WIDTH  to memory addr.
- mem_data_in  out  DATA_WIDTH  to memory data_in.
- mem_write  out  1  to memory mem_write.
- mem_read  out  1  to memory mem_read.
- mem_access_type  out  2  to memory mem_access_type.
- mem_data_out  in  DATA_WIDTH  from memory data_out; combinational read.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values of registered outputs:
  - i_rsp_valid = 0, d_rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - last_grant = D, so the first tie goes to I.
- IDLE:
  - Pick the winner. If only one port has valid, that port wins. If both are valid, the port not in last_grant wins.
  - Assert only the winner's req_ready; the loser's ready is 0.
  - Both readies are 0 outside IDLE and while rst is high.
- Accept is the winner's valid && ready at the edge. On accept:
  - Latch addr, wdata, write, type and the owner; update last_grant to the owner.
  - I requests are latched with type WORD and write = 0.
- Alignment check at accept:
  - HALF requires addr[0] == 0.
  - WORD requires addr[1:0] == 00.
  - BYTE is always aligned.
- Misaligned accept goes to RESP with err = 1 and data = 0. The ACCESS state is skipped, and mem_read/mem_write are never asserted.
- Aligned accept goes to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr, mem_data_in, mem_access_type from the latch.
  - Assert mem_read = !write or mem_write = write.
  - At the closing edge: the memory commits the store; rsp_data captures mem_data_out for a load or 0 for a store; err = 0; go to RESP.
- Memory outputs when not in ACCESS:
  - mem_read = 0, mem_write = 0.
  - mem_addr = 0, mem_data_in = 0.
  - mem_access_type = WORD_MEM_ACCESS.
- RESP:
  - The owner's rsp_valid = 1. Data and err are held stable until the owner's rsp_ready.
  - On rsp_ready, go to IDLE. No new request is accepted in the same cycle.
  - The non-owner's rsp_valid stays 0.
- Latency: accept edge to rsp_valid high is 2 cycles for aligned requests and 1 cycle for misaligned. Minimum throughput is one transaction per 3 cycles.
- Requester rules: a requester holds valid, addr, data and type stable until ready. The arbiter tolerates valid being dropped before ready; nothing is latched in that case.
- Reset mid-operation:
  - mem_read and mem_write are gated by !rst combinationally, so no write occurs in a reset cycle.
  - The next edge returns the FSM to IDLE and clears rsp_valid and the latched transaction. last_grant is reset.
- Address width: the arbiter passes the full address; wrap-around is the memory's concern.

Decomposition:
- Shared core_l0 package:
  - WORD/HALF/BYTE_MEM_ACCESS constants (existing; reuse them, do not redefine).
  - New arb_state_t enum {IDLE, ACCESS, RESP}.
  - New owner_t enum {OWNER_I, OWNER_D}.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from (valid_i, valid_d, last_grant) producing grant_i/grant_d. The FSM, latch and alignment check stay in mem_arbiter.

Test Plan:
- Reset, then D store WORD 0x100 = 0xDEADBEEF, then D load WORD 0x100.
  - Store: d_req_ready in IDLE, mem_write high for exactly 1 cycle, d_rsp_valid 2 cycles after accept with data 0.
  - Load: d_rsp_data = 0xDEADBEEF, err = 0.
- I and D both valid from the first cycle after reset.
  - Grant order is I, D, I, D across 4 back-to-back requests.
  - Never both readies high; never both rsp_valids high.
- D store HALF at 0x203 with data 0x1234.
  - d_rsp_err = 1, 1 cycle after accept; mem_write never asserted.
  - A subsequent BYTE load at 0x203 returns the prior contents.
- Stores BYTE 0x300 = 0xAB and HALF 0x302 = 0xCDEF, then WORD load at 0x300.
  - mem_access_type follows the request type.
  - The WORD load returns 0xCDEF00AB.
- Hold d_rsp_ready = 0 for 5 cycles while i_req_valid = 1.
  - d_rsp_valid and data stay stable; i_req_ready stays 0.
  - I is accepted only after the D response is consumed.
- Assert rst during ACCESS of a store of 0x55 to 0x400.
  - No memory write occurs (a WORD load at 0x400 after reset returns the old value).
  - All rsp_valid = 0 and the FSM is in IDLE the cycle after reset.
